// File: rtl/map_pkg.sv
// Shared types and helpers for the map router: mode width default, the map
// table field layout and the identity initialiser used at reset.
package map_pkg;

  localparam int MAP_MODE_W = 4;
  // Widest source index the field can hold. Narrower builds zero-extend into it.
  localparam int MAP_SRC_W  = 8;

  typedef struct packed {
    logic                 vld;
    logic [MAP_SRC_W-1:0] src;
  } map_field_t;

  // Identity mapping: slot s takes lane s when that lane exists.
  function automatic map_field_t map_ident(input int slot, input int n_in);
    map_field_t f;
    f.vld = (slot < n_in);
    f.src = MAP_SRC_W'(slot);
    return f;
  endfunction

endpackage

// File: rtl/map_router_if.sv
// Beat interface between the L1 ALU lanes and the L2 ALU slots. The master
// side produces input beats and consumes output beats. The slave side is the router.
interface map_router_if #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 8,
  parameter int DW     = 16,
  parameter int MODE_W = map_pkg::MAP_MODE_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*DW-1:0]    in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_OUT*DW-1:0]   out_data;
  logic [MODE_W-1:0]     out_mode;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/map_fifo2.sv
// Two-entry FIFO with registered status. full_o depends on stored state only,
// so the upstream ready signal has no combinational path from pop_i.
module map_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q != 2'd2);
  assign pop_ok  = pop_i  && (cnt_q != 2'd0);
  assign cnt_d   = cnt_q + 2'(push_ok) - 2'(pop_ok);

  assign dout_o  = mem_q[rd_ptr_q];
  assign valid_o = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);

  // NOTE: storage is reset here, although FIFO storage normally is not, because
  // the head entry drives out_data and must read as zero after reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_q ^ push_ok;
      rd_ptr_q <= rd_ptr_q ^ pop_ok;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/map_router.sv
// Lane-to-slot router: each output slot takes one input lane or zero, per a
// per-mode map table. Mapped beats are buffered in a 2-entry FIFO (1-cycle latency).
module map_router
  import map_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 8,
  parameter int DW     = 16,
  parameter int MODE_W = MAP_MODE_W,
  localparam int SW    = (N_IN  > 1) ? $clog2(N_IN)  : 1,
  localparam int SLW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_en,
  input  logic [MODE_W-1:0] mode_in,
  map_router_if.slave       bus,
  input  logic              cfg_we,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [SLW-1:0]    cfg_slot,
  input  logic [SW-1:0]     cfg_src,
  input  logic              cfg_vld,
  output logic              cfg_err,
  output logic [15:0]       beat_cnt
);

  localparam int N_MODES = 2 ** MODE_W;
  localparam int FW      = N_OUT * DW + MODE_W;

  map_field_t           table_q [N_MODES][N_OUT];
  logic [MODE_W-1:0]    mode_q, mode_sel;
  logic                 cfg_err_q;
  logic [15:0]          beat_cnt_q, beat_cnt_d;
  logic [N_OUT*DW-1:0]  mapped;
  map_field_t           fld;
  logic                 cfg_ok, accept, pop, fifo_full;

  assign mode_sel = mode_en ? mode_in : mode_q;
  assign cfg_ok   = cfg_we && (int'(cfg_src) < N_IN);
  assign accept   = bus.in_valid && !fifo_full;
  assign pop      = bus.out_valid && bus.out_ready;

  // NOTE: every variable written here gets a default first, otherwise a slot
  // without a valid source would hold its old value and infer a latch.
  always_comb begin
    mapped = '0;
    fld    = '0;
    for (int s = 0; s < N_OUT; s++) begin
      fld = table_q[mode_sel][s];
      if (fld.vld && (int'(fld.src) < N_IN))
        mapped[(N_OUT-1-s)*DW +: DW] = bus.in_data[(N_IN-1-int'(fld.src))*DW +: DW];
    end
  end

  assign beat_cnt_d = (pop && beat_cnt_q != 16'hFFFF) ? beat_cnt_q + 16'd1 : beat_cnt_q;

  // Table writes land at the edge, so a beat accepted alongside still sees the old map.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int m = 0; m < N_MODES; m++)
        for (int s = 0; s < N_OUT; s++)
          table_q[m][s] <= map_ident(s, N_IN);
      mode_q     <= '0;
      cfg_err_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      if (cfg_ok)
        table_q[cfg_mode][cfg_slot] <= '{vld: cfg_vld, src: MAP_SRC_W'(cfg_src)};
      mode_q     <= mode_sel;
      cfg_err_q  <= cfg_we && !cfg_ok;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  map_fifo2 #(.WIDTH(FW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   ({mapped, mode_sel}),
    .dout_o  ({bus.out_data, bus.out_mode}),
    .valid_o (bus.out_valid),
    .full_o  (fifo_full)
  );

  assign bus.in_ready = !fifo_full;
  assign cfg_err      = cfg_err_q;
  assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_map_router.sv
// Directed bench for map_router: a default build (N_IN=4) and an N_IN=3 build
// that exercises rejection of out-of-range source writes.
module tb_map_router;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Default build
  logic        mode_en_a = 0;
  logic [3:0]  mode_in_a = '0;
  logic        cfg_we_a = 0, cfg_vld_a = 0, cfg_err_a;
  logic [3:0]  cfg_mode_a = '0;
  logic [2:0]  cfg_slot_a = '0;
  logic [1:0]  cfg_src_a = '0;
  logic [15:0] beat_cnt_a;
  map_router_if #(.N_IN(4), .N_OUT(8), .DW(16), .MODE_W(4)) bus_a ();

  map_router #(.N_IN(4), .N_OUT(8), .DW(16), .MODE_W(4)) dut_a (
    .clk(clk), .rst(rst), .mode_en(mode_en_a), .mode_in(mode_in_a), .bus(bus_a.slave),
    .cfg_we(cfg_we_a), .cfg_mode(cfg_mode_a), .cfg_slot(cfg_slot_a), .cfg_src(cfg_src_a),
    .cfg_vld(cfg_vld_a), .cfg_err(cfg_err_a), .beat_cnt(beat_cnt_a)
  );

  // Three-lane build
  logic        mode_en_b = 0;
  logic [3:0]  mode_in_b = '0;
  logic        cfg_we_b = 0, cfg_vld_b = 0, cfg_err_b;
  logic [3:0]  cfg_mode_b = '0;
  logic [2:0]  cfg_slot_b = '0;
  logic [1:0]  cfg_src_b = '0;
  logic [15:0] beat_cnt_b;
  map_router_if #(.N_IN(3), .N_OUT(8), .DW(16), .MODE_W(4)) bus_b ();

  map_router #(.N_IN(3), .N_OUT(8), .DW(16), .MODE_W(4)) dut_b (
    .clk(clk), .rst(rst), .mode_en(mode_en_b), .mode_in(mode_in_b), .bus(bus_b.slave),
    .cfg_we(cfg_we_b), .cfg_mode(cfg_mode_b), .cfg_slot(cfg_slot_b), .cfg_src(cfg_src_b),
    .cfg_vld(cfg_vld_b), .cfg_err(cfg_err_b), .beat_cnt(beat_cnt_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] B1 = 64'h0001_0002_0003_0004;
  localparam logic [63:0] B2 = 64'h0005_0006_0007_0008;
  localparam logic [63:0] B3 = 64'h0009_000A_000B_000C;
  localparam logic [63:0] C1 = 64'h1234_5678_9ABC_DEF0;

  initial begin
    bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0;
    bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.out_ready = 0;

    // Reset state
    tick(); tick();
    check("rst_out_valid", 128'(bus_a.out_valid), 128'(0));
    check("rst_out_data",  bus_a.out_data, 128'h0);
    check("rst_out_mode",  128'(bus_a.out_mode), 128'(0));
    check("rst_beat_cnt",  128'(beat_cnt_a), 128'(0));
    check("rst_cfg_err",   128'(cfg_err_a), 128'(0));
    rst = 1;
    #1;
    check("rst_in_ready",  128'(bus_a.in_ready), 128'(1));

    // Identity mapping, mode 0, one-cycle latency
    bus_a.in_valid = 1; bus_a.in_data = D0; bus_a.out_ready = 1;
    tick();
    check("id_valid", 128'(bus_a.out_valid), 128'(1));
    check("id_data",  bus_a.out_data, {D0, 64'h0});
    check("id_mode",  128'(bus_a.out_mode), 128'(0));
    bus_a.in_valid = 0;
    tick();
    check("id_drain_valid", 128'(bus_a.out_valid), 128'(0));
    check("id_beat_cnt",    128'(beat_cnt_a), 128'(1));

    // Write mode 5 slot 4 <- lane 0, then use mode 5 with and without mode_en
    cfg_we_a = 1; cfg_mode_a = 4'd5; cfg_slot_a = 3'd4; cfg_src_a = 2'd0; cfg_vld_a = 1;
    tick();
    cfg_we_a = 0;
    bus_a.in_valid = 1; bus_a.in_data = D0; mode_en_a = 1; mode_in_a = 4'd5;
    tick();
    check("m5_data", bus_a.out_data, 128'h1111_2222_3333_4444_1111_0000_0000_0000);
    check("m5_mode", 128'(bus_a.out_mode), 128'(5));
    mode_en_a = 0; mode_in_a = 4'd0; bus_a.in_data = D1;
    tick();
    check("m5_sticky_data", bus_a.out_data, 128'hAAAA_BBBB_CCCC_DDDD_AAAA_0000_0000_0000);
    check("m5_sticky_mode", 128'(bus_a.out_mode), 128'(5));
    check("m5_beat_cnt",    128'(beat_cnt_a), 128'(2));
    bus_a.in_valid = 0;
    tick();
    check("m5_drained", 128'(bus_a.out_valid), 128'(0));

    // Backpressure: fill the FIFO, hold, then drain in order
    mode_en_a = 1; mode_in_a = 4'd0; bus_a.out_ready = 0;
    bus_a.in_valid = 1; bus_a.in_data = B1;
    tick();
    check("bp_ready_1", 128'(bus_a.in_ready), 128'(1));
    bus_a.in_data = B2;
    tick();
    check("bp_ready_full", 128'(bus_a.in_ready), 128'(0));
    check("bp_head_b1",    bus_a.out_data, {B1, 64'h0});
    bus_a.in_data = B3;
    tick();
    check("bp_hold_ready", 128'(bus_a.in_ready), 128'(0));
    check("bp_hold_data",  bus_a.out_data, {B1, 64'h0});
    check("bp_hold_mode",  128'(bus_a.out_mode), 128'(0));
    bus_a.out_ready = 1;
    tick();
    check("bp_pop1_ready", 128'(bus_a.in_ready), 128'(1));
    check("bp_head_b2",    bus_a.out_data, {B2, 64'h0});
    tick();
    check("bp_head_b3",  bus_a.out_data, {B3, 64'h0});
    check("bp_valid_b3", 128'(bus_a.out_valid), 128'(1));
    bus_a.in_valid = 0;
    tick();
    check("bp_empty",    128'(bus_a.out_valid), 128'(0));
    check("bp_beat_cnt", 128'(beat_cnt_a), 128'(6));

    // Table write and accept in the same cycle
    cfg_we_a = 1; cfg_mode_a = 4'd0; cfg_slot_a = 3'd0; cfg_src_a = 2'd3; cfg_vld_a = 1;
    bus_a.in_valid = 1; bus_a.in_data = C1;
    tick();
    check("wr_same_old_map", bus_a.out_data, {C1, 64'h0});
    cfg_we_a = 0; bus_a.in_data = D0;
    tick();
    check("wr_next_new_map", bus_a.out_data, 128'h4444_2222_3333_4444_0000_0000_0000_0000);
    bus_a.in_valid = 0;
    tick();

    // Reset with two beats buffered
    bus_a.out_ready = 0; bus_a.in_valid = 1; bus_a.in_data = B1;
    tick();
    bus_a.in_data = B2;
    tick();
    check("mid_full", 128'(bus_a.in_ready), 128'(0));
    bus_a.in_valid = 0; rst = 0;
    tick();
    check("mid_rst_valid",    128'(bus_a.out_valid), 128'(0));
    check("mid_rst_beat_cnt", 128'(beat_cnt_a), 128'(0));
    check("mid_rst_data",     bus_a.out_data, 128'h0);
    rst = 1;
    #1;
    check("mid_rel_ready", 128'(bus_a.in_ready), 128'(1));
    bus_a.in_valid = 1; bus_a.in_data = D0; bus_a.out_ready = 1; mode_en_a = 1; mode_in_a = 4'd5;
    tick();
    check("mid_m5_identity", bus_a.out_data, {D0, 64'h0});
    check("mid_m5_mode",     128'(bus_a.out_mode), 128'(5));
    mode_in_a = 4'd0;
    tick();
    check("mid_m0_identity", bus_a.out_data, {D0, 64'h0});
    bus_a.in_valid = 0;
    tick();

    // Three-lane build: out-of-range source is rejected
    check("b_err_idle", 128'(cfg_err_b), 128'(0));
    cfg_we_b = 1; cfg_mode_b = 4'd0; cfg_slot_b = 3'd0; cfg_src_b = 2'd3; cfg_vld_b = 1;
    tick();
    check("b_err_pulse", 128'(cfg_err_b), 128'(1));
    cfg_we_b = 0;
    tick();
    check("b_err_clear", 128'(cfg_err_b), 128'(0));
    bus_b.in_valid = 1; bus_b.in_data = 48'hAAAA_BBBB_CCCC; bus_b.out_ready = 1;
    tick();
    check("b_table_kept", bus_b.out_data, 128'hAAAA_BBBB_CCCC_0000_0000_0000_0000_0000);
    bus_b.in_valid = 0;
    tick();
    check("b_beat_cnt", 128'(beat_cnt_b), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/map_router.md
MAP_ROUTER -- requirements
Module: map_router

Interface
REQ-001 Parameter N_IN, default 4, number of 16-bit input lanes from the L1 ALU.
REQ-002 Parameter N_OUT, default 8, number of output slots to the L2 ALU.
REQ-003 Parameter DW, default 16, lane/slot data width.
REQ-004 Parameter MODE_W, default 4, mode code width; table depth = 2**MODE_W.
REQ-005 Derived SW = clog2(N_IN), the source-index width.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 mode_en  in  1  loads mode_in into the mode register.
REQ-009 mode_in  in  MODE_W  requested mode code.
REQ-010 in_valid / in_ready  in / out  1 / 1  input beat handshake.
REQ-011 in_data  in  N_IN*DW  lane 0 at MSBs.
REQ-012 out_valid / out_ready  out / in  1 / 1  output beat handshake.
REQ-013 out_data  out  N_OUT*DW  slot 0 at MSBs.
REQ-014 out_mode  out  MODE_W  mode applied to the current out_data beat.
REQ-015 cfg_we, cfg_mode[MODE_W], cfg_slot[clog2 N_OUT], cfg_src[SW], cfg_vld[1]  in  table write port.
REQ-016 cfg_err  out  1  one-cycle pulse on a rejected table write.
REQ-017 beat_cnt  out  16  count of output beats delivered.

Function
REQ-018 Effective mode mode_sel SHALL be mode_in when mode_en=1, else the mode register; the mode register SHALL load mode_sel every cycle.
REQ-019 Map table SHALL hold 2**MODE_W entries x N_OUT fields {vld, src}; slot s of a beat SHALL be in lane src when vld=1, else all zeros.
REQ-020 A beat SHALL be accepted when in_valid and in_ready are both 1; it is mapped with mode_sel and the table contents of that cycle.
REQ-021 Mapped beat plus its mode_sel SHALL be pushed into a 2-entry FIFO; out_valid = FIFO non-empty; out_data/out_mode = FIFO head.
REQ-022 Latency SHALL be exactly 1 cycle: a beat accepted in cycle t is visible with out_valid=1 in cycle t+1 when the FIFO was empty.
REQ-023 in_ready SHALL be 1 iff FIFO count < 2, computed from registered state only (no combinational path from out_ready).
REQ-024 FIFO full and out_ready=1 in the same cycle: pop occurs, no push; in_ready rises the next cycle.
REQ-025 Simultaneous push and pop with count=1 SHALL leave count=1 and keep beat order.
REQ-026 out_data/out_mode SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 Table write (cfg_we=1, cfg_src<N_IN) SHALL update field [cfg_mode][cfg_slot] at the clock edge; beats accepted in the same cycle use the old value.
REQ-028 Table write with cfg_src>=N_IN (only possible when N_IN is not a power of 2) SHALL be ignored and cfg_err SHALL pulse 1 in the next cycle.
REQ-029 beat_cnt SHALL increment on each out_valid and out_ready cycle, saturating at 16'hFFFF.

Reset
REQ-030 On rst=0 at a clock edge: mode register=0, FIFO empty (out_valid=0, out_data=0, out_mode=0), cfg_err=0, beat_cnt=0.
REQ-031 Reset SHALL load every table entry to identity: slot s has vld=1 and src=s for s<N_IN, otherwise vld=0.
REQ-032 Reset mid-operation SHALL discard buffered beats; in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-033 Shared package map_pkg SHALL hold MODE_W default, the table-field struct {vld, src} and the identity-init function.
REQ-034 The 2-entry FIFO SHALL be the sub-module map_fifo2 (parameter width), instantiated once; the table and mapping logic SHALL live in map_router.

Verification
REQ-035 After reset, in_data=64'h1111_2222_3333_4444, mode 0, out_ready=1 -> next cycle out_data=128'h1111_2222_3333_4444_0000..0 and out_mode=0.
REQ-036 Write mode 5, slot 4, src 0, vld 1; send a beat with mode_en=1, mode_in=5 -> slot 4 = 16'h1111 and out_mode=5; the next beat with mode_en=0 still uses mode 5.
REQ-037 out_ready=0, push 3 beats -> in_ready=0 after 2 accepted; raise out_ready -> beats exit in order, third accepted one cycle after the first pop.
REQ-038 Write and accept mode 0 in the same cycle -> that beat uses the old map; the following beat uses the new map.
REQ-039 N_IN=3 build: cfg_src=3 -> table unchanged, cfg_err=1 for exactly one cycle.
REQ-040 rst=0 with 2 beats buffered -> out_valid=0, beat_cnt=0, table back to identity, in_ready=1 after release.
